// File: rtl/llc_trace_dispatcher.sv
// Purpose: buffers LLC trace commands in a small FIFO, decodes each one into a request kind plus
//          tag/index/offset, and issues one request at a time to the LLC engine.
// Latency: a command accepted into an empty FIFO while idle is popped the next cycle and appears as
//          req_valid the cycle after that. The next head is popped the cycle after req_done.
// Backpressure: cmd_ready is low whenever the FIFO is full. The engine stalls issue with req_ready.
//          Only one request is outstanding, held in WAIT until req_done.
//
// Ports:
//   clk, rst_n                      clock and asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_op/cmd_addr      trace command input
//   req_valid/req_ready/req_kind/req_tag/req_index/req_offset   engine request output
//   req_done                        engine completion pulse for the outstanding request
//   err_op                          one-cycle pulse when an illegal op is popped and dropped
//   busy                            FIFO non-empty or FSM not idle
//   stat_issued, stat_illegal       saturating counters, present only with LLC_TRACE_STATS_EN
//
// Optional feature macro: LLC_TRACE_STATS_EN
module llc_trace_dispatcher #(
  parameter int ADDR_W     = 32,
  parameter int SETS       = 16384,
  parameter int LINE_BYTES = 64,
  parameter int FIFO_DEPTH = 4,
  localparam int INDEX_W   = $clog2(SETS),
  localparam int OFF_W     = $clog2(LINE_BYTES),
  localparam int TAG_W     = ADDR_W - INDEX_W - OFF_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_op,
  input  logic [ADDR_W-1:0]  cmd_addr,
  output logic               req_valid,
  input  logic               req_ready,
  output logic [2:0]         req_kind,
  output logic [TAG_W-1:0]   req_tag,
  output logic [INDEX_W-1:0] req_index,
  output logic [OFF_W-1:0]   req_offset,
  input  logic               req_done,
  output logic               err_op,
  output logic               busy
`ifdef LLC_TRACE_STATS_EN
  ,
  output logic [31:0]        stat_issued,
  output logic [15:0]        stat_illegal
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [3:0]        op;
    logic [ADDR_W-1:0] addr;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Returns {legal, kind}. Ops 7 and 10-15 have no engine operation.
  function automatic logic [3:0] decode(input logic [3:0] op);
    case (op)
      4'd0, 4'd2: decode = {1'b1, 3'd0};  // PR_READ
      4'd1:       decode = {1'b1, 3'd1};  // PR_WRITE
      4'd3:       decode = {1'b1, 3'd2};  // SN_READ
      4'd4:       decode = {1'b1, 3'd3};  // SN_WRITE
      4'd5:       decode = {1'b1, 3'd4};  // SN_RWIM
      4'd6:       decode = {1'b1, 3'd5};  // SN_INV
      4'd8:       decode = {1'b1, 3'd6};  // CLEAR
      4'd9:       decode = {1'b1, 3'd7};  // PRINT
      default:    decode = 4'b0000;
    endcase
  endfunction

  // ---------------- command FIFO ----------------
  cmd_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  cmd_t             head;

  // Ready depends on fullness alone, so a pop in the same cycle never opens a slot early.
  assign cmd_ready  = (count != CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = cmd_valid && cmd_ready;
  assign head       = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{op: cmd_op, addr: cmd_addr};
    end
  end

  // Pointers are power-of-two wide, so they wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- issue FSM ----------------
  state_t     state;
  state_t     state_nxt;
  logic       load;
  logic       illegal;
  logic [3:0] head_dec;

  assign head_dec = decode(head.op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    illegal   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_dec[3]) begin
            load      = 1'b1;
            state_nxt = ST_ISSUE;
          end else begin
            illegal = 1'b1;
          end
        end
      end
      ST_ISSUE: if (req_ready) state_nxt = ST_WAIT;
      // req_done is only meaningful here; elsewhere it is ignored.
      ST_WAIT:  if (req_done)  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign req_valid = (state == ST_ISSUE);
  assign busy      = !fifo_empty || (state != ST_IDLE);

  // Request fields are loaded only on pop, so they stay stable through ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_kind   <= '0;
      req_tag    <= '0;
      req_index  <= '0;
      req_offset <= '0;
      err_op     <= 1'b0;
    end else begin
      err_op <= illegal;
      if (load) begin
        req_kind   <= head_dec[2:0];
        req_tag    <= head.addr[ADDR_W-1 -: TAG_W];
        req_index  <= head.addr[OFF_W +: INDEX_W];
        req_offset <= head.addr[OFF_W-1:0];
      end
    end
  end

`ifdef LLC_TRACE_STATS_EN
  // Saturating counters. CLEAR is an engine operation and leaves these counters alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued  <= '0;
      stat_illegal <= '0;
    end else begin
      if (req_valid && req_ready && (stat_issued != '1)) stat_issued  <= stat_issued + 32'd1;
      if (illegal && (stat_illegal != '1))               stat_illegal <= stat_illegal + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_llc_trace_dispatcher.sv
// Directed bench for llc_trace_dispatcher with hand-computed expectations.
// Inputs are driven 1 time unit after the rising edge, and outputs are sampled at that same point.
module tb_llc_trace_dispatcher;

  localparam int ADDR_W  = 32;
  localparam int TAG_W   = 12;
  localparam int INDEX_W = 14;
  localparam int OFF_W   = 6;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [3:0]         cmd_op;
  logic [ADDR_W-1:0]  cmd_addr;
  logic               req_valid;
  logic               req_ready;
  logic [2:0]         req_kind;
  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_index;
  logic [OFF_W-1:0]   req_offset;
  logic               req_done;
  logic               err_op;
  logic               busy;
`ifdef LLC_TRACE_STATS_EN
  logic [31:0]        stat_issued;
  logic [15:0]        stat_illegal;
  int                 n_acc = 0;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  llc_trace_dispatcher #(
    .ADDR_W(32), .SETS(16384), .LINE_BYTES(64), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind), .req_tag(req_tag),
    .req_index(req_index), .req_offset(req_offset), .req_done(req_done),
    .err_op(err_op), .busy(busy)
`ifdef LLC_TRACE_STATS_EN
    , .stat_issued(stat_issued), .stat_illegal(stat_illegal)
`endif
  );

  // Tag, index and offset are contiguous, so the expected field word is {kind, addr}.
  function automatic logic [34:0] fields();
    fields = {req_kind, req_tag, req_index, req_offset};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a request, returns its fields, accepts it, and completes it one cycle later.
  task automatic serve(output logic got, output logic [34:0] f);
    got = 1'b0;
    f   = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (req_valid) got = 1'b1;
      else step();
    end
    if (got) begin
      f = fields();
      req_ready = 1'b1; step(); req_ready = 1'b0;
      req_done  = 1'b1; step(); req_done  = 1'b0;
`ifdef LLC_TRACE_STATS_EN
      n_acc++;
`endif
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; req_ready = 1'b0; req_done = 1'b0;
    #12;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", req_valid); end
    checks++; if (fields() !== 35'd0) begin failures++; $display("FAIL reset_fields got=%h exp=0", fields()); end
    checks++; if (err_op !== 1'b0) begin failures++; $display("FAIL reset_err_op got=%b exp=0", err_op); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
`ifdef LLC_TRACE_STATS_EN
    checks++; if (stat_issued !== 32'd0 || stat_illegal !== 16'd0) begin failures++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", stat_issued, stat_illegal); end
`endif
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  task automatic test_latency();
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_addr = 32'h1234_5678;
    step();  // cycle N accepted; now N+1
    cmd_valid = 1'b0;
    checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL lat_n1_valid got=%b exp=0", req_valid); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL lat_n1_busy got=%b exp=1", busy); end
    step();  // N+2
    checks++; if (req_valid !== 1'b1) begin failures++; $display("FAIL lat_n2_valid got=%b exp=1", req_valid); end
    checks++; if (fields() !== {3'd0, 12'h123, 14'h1159, 6'h38}) begin failures++; $display("FAIL lat_fields got=%h exp=%h", fields(), {3'd0, 12'h123, 14'h1159, 6'h38}); end
    req_ready = 1'b1; step(); req_ready = 1'b0;
`ifdef LLC_TRACE_STATS_EN
    n_acc++;
`endif
    checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL lat_accept_valid got=%b exp=0", req_valid); end
    req_done = 1'b1; step(); req_done = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL lat_done_busy got=%b exp=0", busy); end
  endtask

  task automatic test_fifo_full();
    logic [3:0]  ops [5];
    logic [31:0] adr [5];
    logic        got;
    logic [34:0] f;
    int          extra;
    ops = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd6};
    for (int i = 0; i < 5; i++) adr[i] = 32'hA000_0000 + i * 32'h0010_0041;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_op = ops[i]; cmd_addr = adr[i];
      checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL full_ready_%0d got=%b exp=1", i, cmd_ready); end
      step();
    end
    // Extra PRINT held on the input; it must never enter while full.
    cmd_op = 4'd9; cmd_addr = 32'hFFFF_FFFF;
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL full_block got=%b exp=0", cmd_ready); end
    step();
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL full_block2 got=%b exp=0", cmd_ready); end
    checks++; if (fields() !== {3'd1, adr[0]}) begin failures++; $display("FAIL full_first got=%h exp=%h", fields(), {3'd1, adr[0]}); end
    req_ready = 1'b1; step(); req_ready = 1'b0;
`ifdef LLC_TRACE_STATS_EN
    n_acc++;
`endif
    req_done = 1'b1; step(); req_done = 1'b0;
    // Pop cycle: still full, so ready stays low even though an entry leaves now.
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL full_pop_cycle got=%b exp=0", cmd_ready); end
    step();
    cmd_valid = 1'b0;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL full_after_pop got=%b exp=1", cmd_ready); end
    checks++; if (req_valid !== 1'b1) begin failures++; $display("FAIL full_b2b_valid got=%b exp=1", req_valid); end
    for (int i = 1; i < 5; i++) begin
      serve(got, f);
      checks++; if (got !== 1'b1) begin failures++; $display("FAIL full_drain_timeout_%0d got=no_request exp=request", i); end
      checks++; if (f !== {3'(ops[i] - 4'd1), adr[i]}) begin failures++; $display("FAIL full_drain_%0d got=%h exp=%h", i, f, {3'(ops[i] - 4'd1), adr[i]}); end
    end
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      if (req_valid) extra++;
      step();
    end
    checks++; if (extra !== 0) begin failures++; $display("FAIL full_no_extra got=%0d exp=0", extra); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL full_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_illegal();
    logic        got;
    logic [34:0] f;
    int          pulses;
    pulses = 0;
    cmd_valid = 1'b1; cmd_op = 4'd7; cmd_addr = 32'h5555_5555;
    step();
    cmd_op = 4'd3; cmd_addr = 32'h0;
    step();
    cmd_valid = 1'b0;
    if (err_op) pulses++;
    checks++; if (err_op !== 1'b1) begin failures++; $display("FAIL ill_err_pulse got=%b exp=1", err_op); end
    checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL ill_no_issue got=%b exp=0", req_valid); end
    step();
    if (err_op) pulses++;
    checks++; if (err_op !== 1'b0) begin failures++; $display("FAIL ill_err_clear got=%b exp=0", err_op); end
    checks++; if (req_valid !== 1'b1) begin failures++; $display("FAIL ill_next_valid got=%b exp=1", req_valid); end
    checks++; if (fields() !== {3'd2, 32'h0}) begin failures++; $display("FAIL ill_next_fields got=%h exp=%h", fields(), {3'd2, 32'h0}); end
    serve(got, f);
    if (err_op) pulses++;
    checks++; if (pulses !== 1) begin failures++; $display("FAIL ill_pulse_count got=%0d exp=1", pulses); end
`ifdef LLC_TRACE_STATS_EN
    checks++; if (stat_illegal !== 16'd1) begin failures++; $display("FAIL ill_stat got=%0d exp=1", stat_illegal); end
`endif
  endtask

  task automatic test_stall_spurious();
    logic        got;
    logic [34:0] f;
    req_done = 1'b1; step(); req_done = 1'b0;
    checks++; if (busy !== 1'b0 || req_valid !== 1'b0) begin failures++; $display("FAIL spur_idle got=busy%b/valid%b exp=0/0", busy, req_valid); end
    cmd_valid = 1'b1; cmd_op = 4'd1; cmd_addr = 32'hDEAD_BEEF;
    step();
    cmd_valid = 1'b0;
    step();
    checks++; if (fields() !== {3'd1, 32'hDEAD_BEEF}) begin failures++; $display("FAIL stall_fields got=%h exp=%h", fields(), {3'd1, 32'hDEAD_BEEF}); end
    for (int i = 0; i < 3; i++) begin
      cmd_valid = (i == 0); cmd_op = 4'd8; cmd_addr = 32'h0BAD_F00D;
      req_done  = (i == 1);  // spurious done while in ISSUE
      step();
      checks++; if (req_valid !== 1'b1 || fields() !== {3'd1, 32'hDEAD_BEEF}) begin failures++; $display("FAIL stall_hold_%0d got=%b/%h exp=1/%h", i, req_valid, fields(), {3'd1, 32'hDEAD_BEEF}); end
    end
    cmd_valid = 1'b0; req_done = 1'b0;
    req_ready = 1'b1; step(); req_ready = 1'b0;
`ifdef LLC_TRACE_STATS_EN
    n_acc++;
`endif
    checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL stall_accept got=%b exp=0", req_valid); end
    step();
    checks++; if (req_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL stall_wait got=valid%b/busy%b exp=0/1", req_valid, busy); end
    req_done = 1'b1; step(); req_done = 1'b0;
    checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL b2b_m1 got=%b exp=0", req_valid); end
    step();
    checks++; if (req_valid !== 1'b1) begin failures++; $display("FAIL b2b_m2 got=%b exp=1", req_valid); end
    serve(got, f);
    checks++; if (f !== {3'd6, 32'h0BAD_F00D}) begin failures++; $display("FAIL b2b_fields got=%h exp=%h", f, {3'd6, 32'h0BAD_F00D}); end
`ifdef LLC_TRACE_STATS_EN
    checks++; if (stat_issued !== 32'(n_acc)) begin failures++; $display("FAIL stat_issued got=%0d exp=%0d", stat_issued, n_acc); end
`endif
  endtask

  task automatic test_reset_mid_wait();
    int seen;
    cmd_valid = 1'b1; cmd_op = 4'd4; cmd_addr = 32'h7777_0001;
    step();
    cmd_valid = 1'b0;
    step();
    req_ready = 1'b1; step(); req_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 4'd5; cmd_addr = 32'h1111_2222; step();
    cmd_op = 4'd9; cmd_addr = 32'h3333_4444; step();
    cmd_valid = 1'b0;
    checks++; if (req_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL rst_pre_wait got=valid%b/busy%b exp=0/1", req_valid, busy); end
    #2; rst_n = 1'b0; #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%b exp=1", cmd_ready); end
    checks++; if (req_valid !== 1'b0 || err_op !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b/%b exp=0/0", req_valid, err_op); end
    checks++; if (fields() !== 35'd0) begin failures++; $display("FAIL rst_mid_fields got=%h exp=0", fields()); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
`ifdef LLC_TRACE_STATS_EN
    checks++; if (stat_issued !== 32'd0 || stat_illegal !== 16'd0) begin failures++; $display("FAIL rst_mid_stats got=%0d/%0d exp=0/0", stat_issued, stat_illegal); end
`endif
    @(negedge clk); rst_n = 1'b1;
    step();
    req_done = 1'b1; step(); req_done = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (req_valid || busy) seen++;
      step();
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL rst_post_idle got=%0d active cycles exp=0", seen); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fifo_full();
    test_illegal();
    test_stall_spurious();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
